step_gen: RTL
=============

# step_gen

Debounced push-button single-step generator for the multi-cycle CPU board build. It samples the four raw step buttons and, on a clean press, emits a fixed-length burst of slow, manual-clock pulses on `step_clk`. `step_clk` feeds the manual-clock input of the clock divider, which selects it as the CPU clock when manual mode is chosen. It also reports burst progress and a one-cycle key event for display logic.

## Interface
- `PRE_W`, 17: prescaler width; sample tick every 2^PRE_W clk cycles.
- `DEB_CNT`, 4: consecutive differing samples required to accept a button level change (≥2).
- `clk`  in  1  board clock, all logic on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `BTN`  in  4  raw, asynchronous, active-high buttons; BTN[0..3] request 2/4/10/20 steps.
- `en`  in  1  burst enable; low aborts any burst and blocks new ones.
- `btn_ok`  out  4  debounced button levels (registered).
- `key_ready`  out  1  one-clk pulse when a burst is accepted.
- `step_clk`  out  1  manual CPU clock (registered, glitch-free).
- `busy`  out  1  high while FSM not IDLE.
- `remain`  out  5  steps not yet completed in current burst.

## Operation
- Synchronizer: each BTN bit passes through 2 flops before use; 2-clk input latency.
- Prescaler: `pre_cnt` (PRE_W bits) increments every clk, wraps; `tick` = 1 for the single clk where `pre_cnt` is all-ones.
- Debounce, per bit i, only on tick: if sync sample ≠ btn_ok[i], cnt_i += 1; when cnt_i reaches DEB_CNT-1 (i.e. the DEB_CNT-th differing sample), btn_ok[i] toggles and cnt_i ← 0. Sample equal to btn_ok[i] → cnt_i ← 0. Between ticks counters hold.
- Press event: `press[i] = btn_ok[i] & ~btn_ok_d[i]` (btn_ok_d = btn_ok delayed 1 clk). Releases generate nothing.
- FSM states IDLE, HIGH, LOW:
  - IDLE: if en and any press: pick lowest index i, remain ← {2,4,10,20}[i], step_clk ← 1, key_ready ← 1, → HIGH. Else step_clk = 0, remain = 0.
  - HIGH: on tick: step_clk ← 0, → LOW.
  - LOW: on tick: if remain == 1 → remain ← 0, IDLE; else remain ← remain-1, step_clk ← 1, → HIGH.
- Each burst produces exactly N rising edges of step_clk; remain decrements when each pulse's low phase ends.
- Presses while HIGH/LOW are ignored (not queued). Simultaneous presses: lowest index wins, others discarded.
- en low in any state: next edge forces IDLE, step_clk 0, remain 0, key_ready 0. Debouncer unaffected.
- busy = (state ≠ IDLE), combinational decode of registered state.

## Timing
- Reset (sync): pre_cnt, sync flops, cnt_i, btn_ok, btn_ok_d, step_clk, key_ready, remain all 0; state IDLE; busy 0.
- btn_ok rises at the edge ending the accepting tick cycle; step_clk and key_ready rise exactly 1 clk later; key_ready drops the following clk.
- First high phase: from acceptance to next tick (≤2^PRE_W clks); every later half-phase exactly 2^PRE_W clks.
- Last pulse: step_clk low, remain 0, busy 0 at the tick ending the final LOW phase.
- Press arriving the same cycle the FSM returns to IDLE is ignored (FSM not IDLE that cycle); earliest accepted press is the next cycle.
- Reset mid-burst: all outputs return to reset values at that edge; no partial pulse afterwards.

## Test plan
Use PRE_W=2 (tick every 4 clks), DEB_CNT=3.
- Reset: hold rst 2 clks with BTN=4'hF -> all outputs 0, state IDLE; after release btn_ok[3:0] goes 4'hF only after 3 ticks of stable input.
- Bounce: BTN[0] toggles every 3 clks for 40 clks, then holds 1 -> btn_ok[0] stays 0 during bouncing, rises after 3 stable ticks; exactly 2 step_clk rising edges, each high/low phase 4 clks after the first; key_ready one 1-clk pulse.
- Burst length: clean press BTN[3] -> 20 step_clk rising edges, remain steps 20→0, busy falls with final low phase.
- Priority/ignore: BTN[1] and BTN[2] pressed together -> remain loads 4; BTN[0] pressed mid-burst -> no effect, total edges 4.
- Abort: en drops after 3rd edge of a 10-step burst -> next clk step_clk=0, remain=0, busy=0; en high again with button still held -> no new burst until release and re-press.
- Mid-burst rst: rst at remain=7 -> same-edge return to reset values, no further edges.

Source files
------------

// File: rtl/step_gen.sv
// Debounced push-button burst generator: a clean button press emits a fixed
// number of slow manual-clock pulses on step_clk for the CPU clock divider.
module step_gen #(
    parameter int PRE_W   = 17,
    parameter int DEB_CNT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] BTN,
    input  logic       en,
    output logic [3:0] btn_ok,
    output logic       key_ready,
    output logic       step_clk,
    output logic       busy,
    output logic [4:0] remain
);

    localparam int CNT_W = (DEB_CNT > 2) ? $clog2(DEB_CNT) : 1;

    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    state_t           state, state_nxt;
    logic [3:0]       sync_p0, sync_p1;
    logic [3:0]       btn_ok_d;
    logic [3:0]       press;
    logic [PRE_W-1:0] pre_cnt;
    logic             tick;
    logic [CNT_W-1:0] deb_cnt [4];
    logic             step_clk_nxt;
    logic             key_ready_nxt;
    logic [4:0]       remain_nxt;

    // Lowest-index button wins when several are pressed together.
    function automatic logic [4:0] burst_len(input logic [3:0] p);
        if (p[0])      return 5'd2;
        else if (p[1]) return 5'd4;
        else if (p[2]) return 5'd10;
        else           return 5'd20;
    endfunction

    assign tick  = &pre_cnt;
    assign press = btn_ok & ~btn_ok_d;
    assign busy  = (state != IDLE);

    // Synchronizer, prescaler and per-button debounce counters
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt  <= '0;
            sync_p0  <= '0;
            sync_p1  <= '0;
            btn_ok   <= '0;
            btn_ok_d <= '0;
            for (int i = 0; i < 4; i++) deb_cnt[i] <= '0;
        end else begin
            pre_cnt  <= pre_cnt + PRE_W'(1);
            sync_p0  <= BTN;
            sync_p1  <= sync_p0;
            btn_ok_d <= btn_ok;
            if (tick) begin
                for (int i = 0; i < 4; i++) begin
                    if (sync_p1[i] != btn_ok[i]) begin
                        if (deb_cnt[i] == CNT_W'(DEB_CNT - 1)) begin
                            btn_ok[i]  <= ~btn_ok[i];
                            deb_cnt[i] <= '0;
                        end else begin
                            deb_cnt[i] <= deb_cnt[i] + CNT_W'(1);
                        end
                    end else begin
                        deb_cnt[i] <= '0;
                    end
                end
            end
        end
    end

    // Burst FSM state and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            step_clk  <= 1'b0;
            key_ready <= 1'b0;
            remain    <= '0;
        end else begin
            state     <= state_nxt;
            step_clk  <= step_clk_nxt;
            key_ready <= key_ready_nxt;
            remain    <= remain_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        step_clk_nxt  = step_clk;
        key_ready_nxt = 1'b0;
        remain_nxt    = remain;
        if (!en) begin
            state_nxt    = IDLE;
            step_clk_nxt = 1'b0;
            remain_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|press) begin
                        state_nxt     = HIGH;
                        step_clk_nxt  = 1'b1;
                        key_ready_nxt = 1'b1;
                        remain_nxt    = burst_len(press);
                    end else begin
                        step_clk_nxt = 1'b0;
                        remain_nxt   = '0;
                    end
                end
                HIGH: begin
                    if (tick) begin
                        step_clk_nxt = 1'b0;
                        state_nxt    = LOW;
                    end
                end
                LOW: begin
                    // remain counts down as each low phase completes
                    if (tick) begin
                        if (remain == 5'd1) begin
                            remain_nxt = '0;
                            state_nxt  = IDLE;
                        end else begin
                            remain_nxt   = remain - 5'd1;
                            step_clk_nxt = 1'b1;
                            state_nxt    = HIGH;
                        end
                    end
                end
                default: begin
                    state_nxt    = IDLE;
                    step_clk_nxt = 1'b0;
                    remain_nxt   = '0;
                end
            endcase
        end
    end

endmodule
